// File: rtl/comb_bist_driver.sv
// LFSR-driven BIST for a single-output combinational netlist: applies vectors,
// waits SETTLE_CYCLES, folds the primary output into a 16-bit MISR, checks it.
module comb_bist_driver #(
  parameter int                  PI_WIDTH      = 26,
  parameter logic [PI_WIDTH-1:0] LFSR_TAPS     = 26'h2000023,
  parameter logic [PI_WIDTH-1:0] LFSR_SEED     = 26'h0000001,
  parameter int                  PATTERN_COUNT = 1024,
  parameter int                  SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         expected_sig,
  input  logic                po_bit,
  output logic [PI_WIDTH-1:0] pi_vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         signature,
  output logic [15:0]         pattern_idx
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   LAST_IDX    = 16'(PATTERN_COUNT - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PI_WIDTH-1:0] SEED =
    (LFSR_SEED == '0) ? {{(PI_WIDTH-1){1'b0}}, 1'b1} : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t              state, state_nxt;
  logic [PI_WIDTH-1:0] lfsr;
  logic [PI_WIDTH-1:0] lfsr_step;
  logic [CW-1:0]       settle_cnt;
  logic [15:0]         sig_next;
  logic                last;
  logic                load, capture, abort_go;

  assign lfsr_step = {lfsr[PI_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
  assign sig_next  = {signature[14:0], po_bit} ^ (signature[15] ? 16'h1021 : 16'h0000);
  assign last      = (pattern_idx == LAST_IDX);
  assign busy      = (state == SETTLE) || (state == CAPTURE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    abort_go  = 1'b0;
    case (state)
      IDLE: begin
        // abort takes priority over start even here; it simply keeps us idle
        if (start && !abort) begin
          load      = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abort_go  = 1'b1;
          state_nxt = IDLE;
        end else if (settle_cnt == '0) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          abort_go  = 1'b1;
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = last ? DONE : SETTLE;
        end
      end
      DONE: begin
        if (abort) begin
          abort_go  = 1'b1;
          state_nxt = IDLE;
        end else if (start) begin
          load      = 1'b1;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= '0;
      pi_vec      <= '0;
      settle_cnt  <= '0;
      signature   <= 16'hFFFF;
      pattern_idx <= '0;
      pass        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        lfsr        <= SEED;
        pi_vec      <= SEED;
        signature   <= 16'hFFFF;
        pattern_idx <= '0;
        settle_cnt  <= SETTLE_INIT;
        pass        <= 1'b0;
      end else if (abort_go) begin
        pi_vec <= '0;
        pass   <= 1'b0;
      end else begin
        if (state == SETTLE && settle_cnt != '0)
          settle_cnt <= settle_cnt - 1'b1;
        if (capture) begin
          signature <= sig_next;
          if (last) begin
            pass <= (sig_next == expected_sig);
          end else begin
            lfsr        <= lfsr_step;
            pi_vec      <= lfsr_step;
            pattern_idx <= pattern_idx + 16'd1;
            settle_cnt  <= SETTLE_INIT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_comb_bist_driver.sv
// Bench for comb_bist_driver: cycle-position reference model plus directed
// literal checks, then randomized start/abort/reset/po_bit traffic.
module tb_comb_bist_driver;

  localparam int          W  = 26;
  localparam int          PC = 4;
  localparam int          S  = 2;
  localparam logic [25:0] TAPS = 26'h2000023;
  localparam logic [25:0] SEED = 26'h0000001;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, po_bit = 1'b0;
  logic [15:0] expected_sig = 16'h0;
  logic [W-1:0] pi_vec;
  logic        busy, done, pass;
  logic [15:0] signature, pattern_idx;

  logic        start1 = 1'b0, abort1 = 1'b0, po1 = 1'b0;
  logic [15:0] exp1 = 16'h0;
  logic [W-1:0] pi1;
  logic        busy1, done1, pass1;
  logic [15:0] sig1, idx1;

  comb_bist_driver #(.PATTERN_COUNT(PC), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_sig(expected_sig), .po_bit(po_bit), .pi_vec(pi_vec),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .pattern_idx(pattern_idx));

  comb_bist_driver #(.PATTERN_COUNT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected_sig(exp1), .po_bit(po1), .pi_vec(pi1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1),
    .pattern_idx(idx1));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [25:0] lstep(input logic [25:0] l);
    return {l[24:0], ^(l & TAPS)};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
  endfunction

  // Model: mode 0=idle 1=running 2=done; m_t counts cycles since the start edge,
  // and every (S+1)th cycle of a run is the capture cycle.
  int          m_mode = 0, m_t = 0, m_idx = 0;
  logic [25:0] m_lfsr = '0, m_pi = '0;
  logic [15:0] m_sig = 16'hFFFF;
  logic        m_pass = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= 0; m_t <= 0; m_idx <= 0; m_lfsr <= '0; m_pi <= '0;
      m_sig <= 16'hFFFF; m_pass <= 1'b0;
    end else if (abort && m_mode != 0) begin
      m_mode <= 0; m_pi <= '0; m_pass <= 1'b0;
    end else if (start && !abort && m_mode != 1) begin
      m_mode <= 1; m_t <= 0; m_idx <= 0; m_lfsr <= SEED; m_pi <= SEED;
      m_sig <= 16'hFFFF; m_pass <= 1'b0;
    end else if (m_mode == 1) begin
      m_t <= m_t + 1;
      if (m_t % (S + 1) == S) begin
        m_sig <= misr(m_sig, po_bit);
        if (m_idx == PC - 1) begin
          m_mode <= 2;
          m_pass <= (misr(m_sig, po_bit) == expected_sig);
        end else begin
          m_lfsr <= lstep(m_lfsr);
          m_pi   <= lstep(m_lfsr);
          m_idx  <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_pi_vec", pi_vec, m_pi);
      chk("m_busy", busy, m_mode == 1);
      chk("m_done", done, m_mode == 2);
      chk("m_pass", pass, m_pass);
      chk("m_signature", signature, m_sig);
      chk("m_pattern_idx", pattern_idx, m_idx);
    end
  end

  logic [25:0] vt [4];
  logic [15:0] gold;

  initial begin
    vt[0] = 26'h1; vt[1] = 26'h3; vt[2] = 26'h6; vt[3] = 26'hD;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_pi", pi_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_idx", pattern_idx, 0);
    chk("rst_one_sig", sig1, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // directed full run, po_bit 0, golden computed by repeated MISR
    gold = 16'hFFFF;
    for (int i = 0; i < PC; i++) gold = misr(gold, 1'b0);
    po_bit = 1'b0; expected_sig = gold; start = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k < 12) begin
        chk("dir_pi", pi_vec, vt[k/3]);
        chk("dir_idx", pattern_idx, k / 3);
        chk("dir_busy", busy, 1);
      end
      chk("dir_done", done, k == 12);
    end
    chk("dir_pass", pass, 1);

    // abort in 2nd settle cycle of vector 2 (restart from DONE)
    start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 7) abort = 1'b1;
    end
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pi", pi_vec, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_pi", pi_vec, 26'h1);
    chk("restart_idx", pattern_idx, 0);

    // reset mid-run
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_sig", signature, 16'hFFFF);
    chk("midrst_pi", pi_vec, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", pattern_idx, 0);

    // start while busy is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k < 12) chk("busystart_idx", pattern_idx, k / 3);
      chk("busystart_done", done, k == 12);
    end

    // start+abort in DONE -> idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_done", done, 0);
    chk("sa_busy", busy, 0);
    chk("sa_pi", pi_vec, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("rerun_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_restart_sig", signature, 16'hFFFF);
    chk("done_restart_busy", busy, 1);

    // single-pattern instance, po 0 then po 1
    exp1 = 16'hEFDF;
    for (int r = 0; r < 2; r++) begin
      po1 = (r == 1); start1 = 1'b1;
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        if (k == 0) start1 = 1'b0;
        if (k < 3) begin
          chk("one_pi", pi1, 26'h1);
          chk("one_busy", busy1, 1);
        end
        chk("one_done", done1, k == 3);
      end
      chk("one_sig", sig1, (r == 1) ? 16'hEFDE : 16'hEFDF);
      chk("one_pass", pass1, r == 0);
    end

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 19) == 0);
      abort  = ($urandom_range(0, 59) == 0);
      po_bit = 1'($urandom);
      rst_n  = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 99) == 0) expected_sig = 16'($urandom);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
